// File: rtl/seq_detect_param.sv
// Serial bit-pattern detector with a runtime pattern, length and overlap mode, plus a saturating hit counter.
// match is a registered pulse one cycle after the final pattern bit. There is no backpressure: bits are sampled whenever a_valid is high.
module seq_detect_param #(
   parameter int PAT_W = 8,
   parameter int LEN_W = 4,
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             a,
   input  logic             a_valid,
   input  logic             cfg_load,
   input  logic [PAT_W-1:0] pattern,
   input  logic [LEN_W-1:0] pat_len,
   input  logic             overlap_en,
   input  logic             cnt_clr,
   output logic             match,
   output logic [CNT_W-1:0] match_cnt,
   output logic             cfg_ok
);

   localparam logic [LEN_W-1:0] L_PAT_W   = LEN_W'(PAT_W);
   localparam logic [CNT_W-1:0] L_CNT_MAX = '1;

   logic [PAT_W-1:0] r_pat;
   logic [LEN_W-1:0] r_len;
   logic             r_ovl;
   logic [PAT_W-2:0] r_hist;
   logic [LEN_W-1:0] r_fill;
   logic             r_match;
   logic [CNT_W-1:0] r_cnt;
   logic             r_cfg_ok;

   logic [PAT_W-1:0] w_window;
   logic [PAT_W-1:0] w_mask;
   logic [LEN_W:0]   w_fill_p1;
   logic [LEN_W-1:0] w_len_in;
   logic             w_hit;

   // The incoming bit completes the window, so only the newest PAT_W-1 history bits are ever compared.
   assign w_window = {r_hist, a};

   always_comb begin
      w_mask = '0;
      for (int i = 0; i < PAT_W; i++) begin
         w_mask[i] = (LEN_W'(i) < r_len);
      end
   end

   assign w_fill_p1 = {1'b0, r_fill} + {{LEN_W{1'b0}}, 1'b1};
   assign w_len_in  = (pat_len > L_PAT_W) ? L_PAT_W : pat_len;

   assign w_hit = a_valid & ~cfg_load & r_cfg_ok
                & (w_fill_p1 >= {1'b0, r_len})
                & (((w_window ^ r_pat) & w_mask) == '0);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_pat    <= '0;
         r_len    <= '0;
         r_ovl    <= 1'b0;
         r_cfg_ok <= 1'b0;
         r_hist   <= '0;
         r_fill   <= '0;
      end else if (cfg_load) begin
         r_pat    <= pattern;
         r_len    <= w_len_in;
         r_ovl    <= overlap_en;
         r_cfg_ok <= (pat_len != '0);
         r_hist   <= '0;
         r_fill   <= '0;
      end else if (a_valid) begin
         r_hist <= w_window[PAT_W-2:0];
         // Non-overlapping mode restarts the fill so no bit is shared between detections.
         if (w_hit && !r_ovl) begin
            r_fill <= '0;
         end else if (r_fill != L_PAT_W) begin
            r_fill <= w_fill_p1[LEN_W-1:0];
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_match <= 1'b0;
         r_cnt   <= '0;
      end else begin
         r_match <= w_hit;
         if (cnt_clr) begin
            r_cnt <= w_hit ? CNT_W'(1) : '0;
         end else if (w_hit && (r_cnt != L_CNT_MAX)) begin
            r_cnt <= r_cnt + CNT_W'(1);
         end
      end
   end

   assign match     = r_match;
   assign match_cnt = r_cnt;
   assign cfg_ok    = r_cfg_ok;

endmodule

// File: tb/tb_seq_detect_param.sv
// Scoreboard bench for seq_detect_param: directed bit streams queue the expected match cycle and counts,
// and a monitor pops and compares them whenever match pulses.
module tb_seq_detect_param;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       a = 1'b0;
   logic       a_valid = 1'b0;
   logic       cfg_load = 1'b0;
   logic       cnt_clr = 1'b0;
   logic       overlap_en = 1'b0;
   logic [7:0] pattern = '0;
   logic [3:0] pat_len = '0;
   logic       match, match2, cfg_ok, cfg_ok2;
   logic [7:0] match_cnt;
   logic [1:0] match_cnt2;

   seq_detect_param #(.PAT_W(8), .LEN_W(4), .CNT_W(8)) dut (
      .clk(clk), .rst_n(rst_n), .a(a), .a_valid(a_valid), .cfg_load(cfg_load),
      .pattern(pattern), .pat_len(pat_len), .overlap_en(overlap_en), .cnt_clr(cnt_clr),
      .match(match), .match_cnt(match_cnt), .cfg_ok(cfg_ok)
   );

   seq_detect_param #(.PAT_W(8), .LEN_W(4), .CNT_W(2)) dut_w2 (
      .clk(clk), .rst_n(rst_n), .a(a), .a_valid(a_valid), .cfg_load(cfg_load),
      .pattern(pattern), .pat_len(pat_len), .overlap_en(overlap_en), .cnt_clr(cnt_clr),
      .match(match2), .match_cnt(match_cnt2), .cfg_ok(cfg_ok2)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      int tag;
      int c8;
      int c2;
   } exp_t;

   exp_t sb_q[$];
   int   n_chk = 0;
   int   n_err = 0;
   int   c8 = 0;
   int   c2 = 0;

   logic [7:0] p1 = 8'b01110001;
   logic [4:0] s2_bits = 5'b10101;
   logic [4:0] s2_hit_ovl = 5'b00101;
   logic [4:0] s2_hit_nov = 5'b00100;
   logic [6:0] s5_tail = 7'b1110001;

   task automatic check(input string name, input int act, input int exp);
      n_chk++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   // Drive one cycle of stimulus; a hand-marked hit queues the expected counts for the following cycle.
   task automatic step(input logic v, input logic b, input logic clr, input logic hit);
      @(negedge clk);
      a_valid  = v;
      a        = b;
      cfg_load = 1'b0;
      cnt_clr  = clr;
      if (clr) begin
         c8 = hit ? 1 : 0;
         c2 = hit ? 1 : 0;
      end else if (hit) begin
         if (c8 < 255) c8++;
         if (c2 < 3) c2++;
      end
      if (hit) sb_q.push_back('{cyc + 1, c8, c2});
   endtask

   task automatic load(input logic [7:0] p, input logic [3:0] l, input logic o,
                       input logic v, input logic b);
      @(negedge clk);
      pattern    = p;
      pat_len    = l;
      overlap_en = o;
      cfg_load   = 1'b1;
      a_valid    = v;
      a          = b;
      cnt_clr    = 1'b0;
   endtask

   task automatic settle;
      @(posedge clk);
      #1;
   endtask

   task automatic send8(input logic [7:0] bits, input logic last_hit);
      for (int i = 7; i >= 0; i--) begin
         step(1'b1, bits[i], 1'b0, last_hit && (i == 0));
      end
   endtask

   always @(negedge clk) begin
      if (match) begin
         if (sb_q.size() == 0 || sb_q[0].tag != cyc) begin
            n_chk++;
            n_err++;
            $display("FAIL unexpected_match: match=1 at cycle %0d, expected 0", cyc);
         end else begin
            exp_t e;
            e = sb_q.pop_front();
            check("match_cnt", int'(match_cnt), e.c8);
            check("match_cnt_w2", int'(match_cnt2), e.c2);
            check("match_w2", int'(match2), 1);
         end
      end
      if (sb_q.size() > 0 && sb_q[0].tag <= cyc) begin
         n_chk++;
         n_err++;
         $display("FAIL missed_match: match=0 at cycle %0d, expected 1 at cycle %0d", cyc, sb_q[0].tag);
         void'(sb_q.pop_front());
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation still running at %0t, expected finish", $time);
      $fatal(1);
   end

   initial begin
      repeat (2) @(negedge clk);
      check("rst_match", int'(match), 0);
      check("rst_cnt", int'(match_cnt), 0);
      check("rst_cfg_ok", int'(cfg_ok), 0);
      check("rst_cfg_ok_w2", int'(cfg_ok2), 0);
      rst_n = 1'b1;

      // No detection before the first configuration.
      send8(p1, 1'b0);

      // Scenario 1: full-length pattern.
      load(p1, 4'd8, 1'b1, 1'b0, 1'b0);
      settle;
      check("s1_cfg_ok", int'(cfg_ok), 1);
      send8(p1, 1'b1);
      settle;
      check("s1_cnt", int'(match_cnt), 1);

      // Scenario 2: 101 with overlap, upper pattern bits set to exercise masking.
      step(1'b0, 1'b0, 1'b1, 1'b0);
      load(8'b10101101, 4'd3, 1'b1, 1'b0, 1'b0);
      for (int i = 4; i >= 0; i--) step(1'b1, s2_bits[i], 1'b0, s2_hit_ovl[i]);
      settle;
      check("s2_ovl_cnt", int'(match_cnt), 2);
      step(1'b0, 1'b0, 1'b1, 1'b0);
      load(8'b10101101, 4'd3, 1'b0, 1'b0, 1'b0);
      for (int i = 4; i >= 0; i--) step(1'b1, s2_bits[i], 1'b0, s2_hit_nov[i]);
      settle;
      check("s2_novl_cnt", int'(match_cnt), 1);

      // Scenario 3: two-cycle a_valid gaps after bits 2 and 5.
      step(1'b0, 1'b0, 1'b1, 1'b0);
      load(p1, 4'd8, 1'b1, 1'b0, 1'b0);
      for (int i = 7; i >= 0; i--) begin
         step(1'b1, p1[i], 1'b0, i == 0);
         if (i == 6 || i == 3) repeat (2) step(1'b0, 1'b0, 1'b0, 1'b0);
      end
      settle;
      check("s3_cnt", int'(match_cnt), 1);

      // Scenario 4: len=1, saturation of the 2-bit counter, clear concurrent with a hit.
      step(1'b0, 1'b0, 1'b1, 1'b0);
      load(8'b11110001, 4'd1, 1'b1, 1'b0, 1'b0);
      repeat (5) step(1'b1, 1'b1, 1'b0, 1'b1);
      step(1'b1, 1'b0, 1'b0, 1'b0);
      settle;
      check("s4_sat_cnt_w2", int'(match_cnt2), 3);
      step(1'b1, 1'b1, 1'b1, 1'b1);
      settle;
      check("s4_clr_hit_w2", int'(match_cnt2), 1);
      check("s4_clr_hit", int'(match_cnt), 1);

      // Scenario 5a: zero length never matches.
      step(1'b0, 1'b0, 1'b1, 1'b0);
      load(p1, 4'd0, 1'b1, 1'b0, 1'b0);
      settle;
      check("s5_len0_cfg_ok", int'(cfg_ok), 0);
      send8(p1, 1'b0);
      repeat (4) step(1'b1, 1'b1, 1'b0, 1'b0);
      settle;
      check("s5_len0_cnt", int'(match_cnt), 0);

      // Scenario 5b: length 15 clamps to 8.
      load(p1, 4'd15, 1'b1, 1'b0, 1'b0);
      settle;
      check("s5_clamp_cfg_ok", int'(cfg_ok), 1);
      send8(p1, 1'b1);
      settle;
      check("s5_clamp_cnt", int'(match_cnt), 1);

      // Scenario 5c: the bit presented with cfg_load is dropped, so the 7-bit tail cannot complete a match.
      load(p1, 4'd8, 1'b1, 1'b1, 1'b0);
      for (int i = 6; i >= 0; i--) step(1'b1, s5_tail[i], 1'b0, 1'b0);
      send8(p1, 1'b1);
      settle;
      check("s5_discard_cnt", int'(match_cnt), 2);

      // Scenario 6: asynchronous reset during bit 6.
      load(p1, 4'd8, 1'b1, 1'b0, 1'b0);
      for (int i = 7; i >= 2; i--) step(1'b1, p1[i], 1'b0, 1'b0);
      #2 rst_n = 1'b0;
      #1;
      check("s6_rst_match", int'(match), 0);
      check("s6_rst_cnt", int'(match_cnt), 0);
      check("s6_rst_cnt_w2", int'(match_cnt2), 0);
      check("s6_rst_cfg_ok", int'(cfg_ok), 0);
      c8 = 0;
      c2 = 0;
      #1 rst_n = 1'b1;
      step(1'b1, p1[1], 1'b0, 1'b0);
      step(1'b1, p1[0], 1'b0, 1'b0);
      step(1'b0, 1'b0, 1'b0, 1'b0);
      settle;
      check("s6_post_cnt", int'(match_cnt), 0);
      check("s6_post_cfg_ok", int'(cfg_ok), 0);

      repeat (3) step(1'b0, 1'b0, 1'b0, 1'b0);
      settle;
      check("sb_empty", sb_q.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end

endmodule

// File: doc/seq_detect_param.md
Name: seq_detect_param

Overview:
Parametrised serial bit-pattern detector. It is the successor to the fixed 8-bit sequence detector. The pattern, its length and the overlap mode are runtime-configurable. Input uses a valid-qualified serial bit stream, and the block keeps a saturating match counter. It sits on the serial receive path and flags frame or sync words to downstream control logic.

Parameters:
- PAT_W, 8, maximum pattern length in bits (≥2).
- LEN_W, 4, width of the pat_len port; must hold the value PAT_W.
- CNT_W, 8, width of the saturating match counter.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  reset, asynchronous, active-low.
- a  input  1  serial data bit.
- a_valid  input  1  a is sampled only when high.
- cfg_load  input  1  one-cycle pulse: latch pattern, pat_len and overlap_en; clear history.
- pattern  input  PAT_W  target pattern. pattern[pat_len-1] is the first bit received; pattern[0] is the last.
- pat_len  input  LEN_W  active pattern length.
- overlap_en  input  1  1 = overlapping detection; 0 = non-overlapping.
- cnt_clr  input  1  synchronous clear of match_cnt.
- match  output  1  registered one-cycle pulse per detection.
- match_cnt  output  CNT_W  saturating count of detections.
- cfg_ok  output  1  latched configuration is valid (1 ≤ len ≤ PAT_W).

Behaviour:
- Reset (rst_n low, asynchronous):
  - Latched pattern = 0, len = 0, overlap = 0.
  - History = 0, fill = 0.
  - match = 0, match_cnt = 0, cfg_ok = 0.
  - No detection occurs until the first cfg_load.
- Config:
  - On a clk edge with cfg_load = 1, latch pattern, overlap_en and len.
  - pat_len > PAT_W is clamped to PAT_W.
  - cfg_ok <= (pat_len != 0).
  - History and fill are cleared.
  - match <= 0.
  - If a_valid is also high in that cycle, that bit is discarded.
- History: PAT_W-bit shift register. On an edge with a_valid = 1 and cfg_load = 0:
  - hist <= {hist[PAT_W-2:0], a}.
  - fill <= min(fill + 1, PAT_W).
  - a_valid = 0 leaves hist, fill and match_cnt unchanged; match <= 0.
- Detection (combinational):
  - hit = a_valid & ~cfg_load & cfg_ok & (fill + 1 ≥ len).
  - In addition, the low len bits of {hist, a} must equal pattern[len-1:0].
  - The comparison uses the incoming bit, so the final bit of the pattern is checked in the cycle it arrives.
- Output timing:
  - match <= hit, so match is high in the cycle after the final pattern bit is sampled.
  - Latency is 1 cycle, and match is never held for more than one cycle per hit.
- Overlap modes:
  - overlap = 1: history is unaffected by a hit. A suffix of the pattern that is also a prefix can contribute to the next detection.
  - overlap = 0: on a hit, fill <= 0. The next detection needs len fresh bits, so no bit is shared between detections.
- Counter:
  - cnt_clr = 1: match_cnt <= 0. If hit occurs in the same cycle, match_cnt <= 1 (clear then count).
  - Otherwise a hit increments match_cnt, saturating at 2^CNT_W-1 with no wrap.
  - cfg_load does not clear the counter.
- Boundary conditions:
  - len = 1 matches on every sampled bit equal to pattern[0].
  - len = PAT_W uses the full register.
  - Pattern bits above len-1 are ignored.
  - Gaps in a_valid between pattern bits do not break a match.
- Reset mid-stream: everything clears immediately, including a pending match; a configuration reload is required afterwards.

Test Plan:
1. Reset, then cfg_load with pattern=8'b01110001, len=8, overlap_en=1. Stream 0,1,1,1,0,0,0,1 with a_valid held high.
   - Required: match is a single pulse one cycle after the 8th bit.
   - Required: match_cnt=1; no match before the 8th bit.
2. pattern=3'b101, len=3, overlap_en=1. Stream 1,0,1,0,1.
   - Required: two match pulses, after bit 3 and after bit 5; match_cnt=2.
   - Repeat with overlap_en=0: only one pulse (after bit 3); match_cnt=1.
3. Pattern as in scenario 1, with the stream split by a_valid=0 gaps of 2 cycles after bits 2 and 5.
   - Required: one match pulse one cycle after the 8th valid bit.
   - Required: match stays low during the gaps.
4. CNT_W=2, pattern=1'b1, len=1. Send 5 ones.
   - Required: match_cnt reads 1, 2, 3, 3, 3 (saturates, no wrap).
   - Then assert cnt_clr concurrently with a hit: required match_cnt=1.
5. Configuration boundaries:
   - cfg_load with pat_len=0: cfg_ok=0 and no match for any stream.
   - cfg_load with pat_len=15 (PAT_W=8): clamped to 8, and scenario 1 passes.
   - cfg_load with a_valid=1 in the same cycle: that bit is discarded.
6. Assert rst_n low asynchronously between clock edges during bit 6 of scenario 1.
   - Required: match and match_cnt go to 0 immediately.
   - Required: after release, with no cfg_load, no match for the remaining stream.
